// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative integer multiply/divide unit for the E stage.
//
// Divide is restoring radix-2 and produces one quotient bit per cycle, MSB first.
// Multiply is shift-add and consumes one multiplier bit per cycle, LSB first.
// Both take WIDTH cycles in CALC. A divide by zero skips CALC and goes through
// the single-cycle ZERO state. Signed operations iterate on absolute values.
// The sign correction is applied as the result is registered on entry to DONE.
//
// Optional feature: define MULDIV_MUL_EN to build the multiply datapath.
// Without it, a multiply request goes straight to DONE with a zero result.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   start_i    request pulse, accepted only in IDLE
//   op_i       00 DIVU, 01 DIV, 10 MULTU, 11 MULT (sampled with start_i)
//   a_i, b_i   dividend/multiplicand, divisor/multiplier (sampled with start_i)
//   cancel_i   abort the current operation; the unit returns to IDLE
//   busy_o     high in CALC and ZERO
//   done_o     one-cycle pulse; result_o is valid
//   div0_o     high with done_o when a divide had b = 0
//   result_o   divide: {remainder, quotient}; multiply: {hi, lo}
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               cancel_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               div0_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StZero, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // hi: partial remainder / product high half; lo: dividend-quotient / multiplier-product low half
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  // opnd: divisor for divide, multiplicand for multiply
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               div0_q, div0_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               sign_a_in, sign_b_in;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic [WIDTH-1:0]   div_hi, div_lo;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] div_res;

`ifdef MULDIV_MUL_EN
  logic               mul_q, mul_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi, mul_lo;
  logic [2*WIDTH-1:0] prod_fix;
`endif

  // Operand conditioning: signed ops work on magnitudes and remember the signs.
  always_comb begin
    sign_a_in = op_i[0] & a_i[WIDTH-1];
    sign_b_in = op_i[0] & b_i[WIDTH-1];
    a_abs     = sign_a_in ? -a_i : a_i;
    b_abs     = sign_b_in ? -b_i : b_i;
  end

  // One restoring-division step: shift in the next dividend bit, then try to subtract.
  always_comb begin
    rem_shift = {hi_q, lo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd_q};
    if (!rem_diff[WIDTH]) begin
      div_hi = rem_diff[WIDTH-1:0];
      div_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_hi = rem_shift[WIDTH-1:0];
      div_lo = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

`ifdef MULDIV_MUL_EN
  // One shift-add step: add the multiplicand when the current multiplier bit is set,
  // then shift {carry, hi, lo} right by one bit.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
  end
`endif

  // Pick the active step. The final step result feeds sign correction directly,
  // so the corrected value is registered on the same edge that enters DONE.
  always_comb begin
`ifdef MULDIV_MUL_EN
    step_hi  = mul_q ? mul_hi : div_hi;
    step_lo  = mul_q ? mul_lo : div_lo;
    prod_fix = {step_hi, step_lo};
    if (sign_a_q ^ sign_b_q) begin
      prod_fix = -prod_fix;
    end
`else
    step_hi = div_hi;
    step_lo = div_lo;
`endif
    quo_fix = (sign_a_q ^ sign_b_q) ? -step_lo : step_lo;
    rem_fix = sign_a_q ? -step_hi : step_hi;
    div_res = {rem_fix, quo_fix};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    result_d = result_q;
`ifdef MULDIV_MUL_EN
    mul_d    = mul_q;
`endif

    if (cancel_i) begin
      // Abort: drop any work in flight, leave result_o untouched.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            cnt_d    = '0;
            hi_d     = '0;
            sign_a_d = sign_a_in;
            sign_b_d = sign_b_in;
            div0_d   = 1'b0;
            if (!op_i[1]) begin
`ifdef MULDIV_MUL_EN
              mul_d  = 1'b0;
`endif
              opnd_d = b_abs;
              if (b_i == '0) begin
                // Keep the raw dividend for the {a, all-ones} divide-by-zero result.
                state_d = StZero;
                lo_d    = a_i;
                div0_d  = 1'b1;
              end else begin
                state_d = StCalc;
                lo_d    = a_abs;
              end
            end else begin
`ifdef MULDIV_MUL_EN
              mul_d   = 1'b1;
              opnd_d  = a_abs;
              lo_d    = b_abs;
              state_d = StCalc;
`else
              state_d  = StDone;
              result_d = '0;
`endif
            end
          end
        end
        StCalc: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StDone;
            cnt_d   = '0;
`ifdef MULDIV_MUL_EN
            result_d = mul_q ? prod_fix : div_res;
`else
            result_d = div_res;
`endif
          end
        end
        StZero: begin
          state_d  = StDone;
          result_d = {lo_q, {WIDTH{1'b1}}};
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
      result_q <= result_d;
    end
  end

`ifdef MULDIV_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_q <= 1'b0;
    end else begin
      mul_q <= mul_d;
    end
  end
`endif

  always_comb begin
    busy_o   = (state_q == StCalc) || (state_q == StZero);
    done_o   = (state_q == StDone);
    div0_o   = (state_q == StDone) && div0_q;
    result_o = result_q;
  end

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;

  typedef struct packed {
    logic        div0;
    logic [63:0] res;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start32, cancel32;
  logic [1:0]  op32;
  logic [31:0] a32, b32;
  logic        busy32, done32, div0_32;
  logic [63:0] res32;

  logic        start8, cancel8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, div0_8;
  logic [15:0] res8;

  int          n_tests;
  int          n_fail;
  exp_t        sb_q[$];
  logic [63:0] last_res;

  muldiv_iter #(.WIDTH(32)) u_dut32 (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start32),
    .op_i     (op32),
    .a_i      (a32),
    .b_i      (b32),
    .cancel_i (cancel32),
    .busy_o   (busy32),
    .done_o   (done32),
    .div0_o   (div0_32),
    .result_o (res32)
  );

  muldiv_iter #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start8),
    .op_i     (op8),
    .a_i      (a8),
    .b_i      (b8),
    .cancel_i (cancel8),
    .busy_o   (busy8),
    .done_o   (done8),
    .div0_o   (div0_8),
    .result_o (res8)
  );

  always #5 clk = ~clk;

  // Reference model built on 64-bit arithmetic so MIN / -1 cannot overflow.
  function automatic exp_t model32(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    exp_t   e;
    longint sav, sbv, q, r;
    e = '0;
    sav = longint'($signed(a));
    sbv = longint'($signed(b));
    if (!op[1]) begin
      if (b == 32'd0) begin
        e.div0 = 1'b1;
        e.res  = {a, 32'hFFFF_FFFF};
      end else if (op[0]) begin
        q     = sav / sbv;
        r     = sav % sbv;
        e.res = {r[31:0], q[31:0]};
      end else begin
        e.res = {a % b, a / b};
      end
    end else begin
`ifdef MULDIV_MUL_EN
      if (op[0]) begin
        q     = sav * sbv;
        e.res = q;
      end else begin
        e.res = {32'd0, a} * {32'd0, b};
      end
`endif
    end
    return e;
  endfunction

  function automatic int lat32(input logic [1:0] op, input logic [31:0] b);
    if (!op[1] && b == 32'd0) return 2;
`ifndef MULDIV_MUL_EN
    if (op[1]) return 1;
`endif
    return 33;
  endfunction

  // Drive a start so it is sampled by the next rising edge (edge 0); returns in cycle 1.
  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start32 = 1'b1;
    op32    = op;
    a32     = a;
    b32     = b;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    op32    = 2'($urandom);
    a32     = $urandom;
    b32     = $urandom;
  endtask

  // Wait for done32, counting cycles from 1; tallies cycles where busy32 disagrees with
  // "high before done, low at done".
  task automatic wait_done32(input int limit, output int cyc, output int busy_bad);
    cyc      = 0;
    busy_bad = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (done32 === 1'b1) begin
        if (busy32 !== 1'b0) busy_bad++;
      end else if (busy32 !== 1'b1) begin
        busy_bad++;
      end
    end while (done32 !== 1'b1 && cyc < limit);
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({busy32, done32, div0_32, res32} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset32: got busy=%b done=%b div0=%b res=%h, want all zero",
               busy32, done32, div0_32, res32);
    end
    n_tests++;
    if ({busy8, done8, div0_8, res8} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset8: got busy=%b done=%b div0=%b res=%h, want all zero",
               busy8, done8, div0_8, res8);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_divu();
    exp_t e;
    int   cyc, busy_bad;
    sb_q.push_back(model32(2'b00, 32'd100, 32'd7));
    issue32(2'b00, 32'd100, 32'd7);
    wait_done32(40, cyc, busy_bad);
    n_tests++;
    if (done32 !== 1'b1 || cyc != 33) begin
      n_fail++;
      $display("FAIL divu_latency: done=%b at cycle %0d, want done in cycle 33", done32, cyc);
    end
    n_tests++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL divu_busy: %0d bad busy cycles, want 0", busy_bad);
    end
    e = sb_q.pop_front();
    n_tests++;
    if (res32 !== e.res || res32 !== {32'd2, 32'd14} || div0_32 !== 1'b0) begin
      n_fail++;
      $display("FAIL divu_result: got %h div0=%b, want %h div0=0", res32, div0_32, e.res);
    end
    last_res = e.res;
  endtask

  task automatic test_ops(input string name, input logic [1:0] ops[$],
                          input logic [31:0] as[$], input logic [31:0] bs[$]);
    exp_t e;
    int   cyc, busy_bad, lat;
    for (int i = 0; i < ops.size(); i++) begin
      sb_q.push_back(model32(ops[i], as[i], bs[i]));
      lat = lat32(ops[i], bs[i]);
      issue32(ops[i], as[i], bs[i]);
      wait_done32(40, cyc, busy_bad);
      n_tests++;
      if (done32 !== 1'b1 || cyc != lat) begin
        n_fail++;
        $display("FAIL %s_latency[%0d]: done=%b at cycle %0d, want cycle %0d",
                 name, i, done32, cyc, lat);
      end
      n_tests++;
      if (busy_bad != 0) begin
        n_fail++;
        $display("FAIL %s_busy[%0d]: %0d bad busy cycles, want 0", name, i, busy_bad);
      end
      e = sb_q.pop_front();
      n_tests++;
      if (res32 !== e.res || div0_32 !== e.div0) begin
        n_fail++;
        $display("FAIL %s_result[%0d]: op=%b a=%h b=%h got %h div0=%b, want %h div0=%b",
                 name, i, ops[i], as[i], bs[i], res32, div0_32, e.res, e.div0);
      end
      last_res = e.res;
    end
  endtask

  task automatic test_div();
    logic [1:0]  ops[$];
    logic [31:0] as[$], bs[$];
    ops = '{2'b01, 2'b01};
    as  = '{32'hFFFF_FFF9, 32'h8000_0000};
    bs  = '{32'd2, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      ops.push_back({1'b0, 1'(i)});
      as.push_back($urandom);
      bs.push_back((i < 3) ? 32'($urandom_range(1, 1000)) : ($urandom | 32'd1));
    end
    test_ops("div", ops, as, bs);
    // Fixed expectations straight from the definition of truncating division.
    n_tests++;
    if (model32(2'b01, 32'hFFFF_FFF9, 32'd2) !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_fail++;
      $display("FAIL div_model_neg7: model disagrees with {ffffffff, fffffffd}");
    end
    n_tests++;
    if (last_res !== model32(ops[ops.size()-1], as[as.size()-1], bs[bs.size()-1]).res) begin
      n_fail++;
      $display("FAIL div_last_result: got %h", last_res);
    end
  endtask

  task automatic test_mul();
    logic [1:0]  ops[$];
    logic [31:0] as[$], bs[$];
    ops = '{2'b11, 2'b10, 2'b11, 2'b10};
    as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, $urandom, $urandom};
    bs  = '{32'd2, 32'd2, $urandom, $urandom};
    test_ops("mul", ops, as, bs);
`ifdef MULDIV_MUL_EN
    sb_q.push_back('{div0: 1'b0, res: 64'hFFFF_FFFF_FFFF_FFFE});
    issue32(2'b11, 32'hFFFF_FFFF, 32'd2);
    begin
      int   cyc, busy_bad;
      exp_t e;
      wait_done32(40, cyc, busy_bad);
      e = sb_q.pop_front();
      n_tests++;
      if (done32 !== 1'b1 || res32 !== e.res) begin
        n_fail++;
        $display("FAIL mult_const: got %h done=%b, want %h", res32, done32, e.res);
      end
      last_res = e.res;
    end
`endif
  endtask

  task automatic test_div0();
    logic [1:0]  ops[$];
    logic [31:0] as[$], bs[$];
    ops = '{2'b00, 2'b01};
    as  = '{32'h0000_1234, 32'hFFFF_FF00};
    bs  = '{32'd0, 32'd0};
    test_ops("div0", ops, as, bs);
    n_tests++;
    if (last_res !== {32'hFFFF_FF00, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL div0_signed_result: got %h, want ffffff00ffffffff", last_res);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   done_cyc, n_done, busy_late;
    e = model32(2'b00, 32'd1000, 32'd9);
    sb_q.push_back(e);
    issue32(2'b00, 32'd1000, 32'd9);
    done_cyc  = 0;
    n_done    = 0;
    busy_late = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 5) begin
        start32 = 1'b1;
        op32    = 2'b00;
        a32     = 32'd77;
        b32     = 32'd0;
      end
      if (c == 6) start32 = 1'b0;
      if (c == 34) begin
        start32 = 1'b0;
        if (busy32 !== 1'b0) busy_late++;
      end
      if (c > 34 && busy32 !== 1'b0) busy_late++;
      if (done32 === 1'b1) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = c;
          e = sb_q.pop_front();
          n_tests++;
          if (res32 !== e.res || div0_32 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_result: got %h div0=%b, want %h", res32, div0_32, e.res);
          end
          last_res = e.res;
          // A start during DONE must be ignored.
          start32 = 1'b1;
          op32    = 2'b00;
          a32     = 32'd5;
          b32     = 32'd1;
        end
      end
    end
    n_tests++;
    if (n_done != 1 || done_cyc != 33) begin
      n_fail++;
      $display("FAIL b2b_done: %0d pulses, first at cycle %0d, want 1 pulse at 33",
               n_done, done_cyc);
    end
    n_tests++;
    if (busy_late != 0) begin
      n_fail++;
      $display("FAIL b2b_ignored_start: busy seen %0d times after DONE, want 0", busy_late);
    end
  endtask

  task automatic test_cancel();
    exp_t e;
    int   done_cyc, n_done, n_idle_done;
    issue32(2'b00, 32'd500, 32'd3);
    done_cyc = 0;
    n_done   = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 10) cancel32 = 1'b1;
      if (c == 11) begin
        cancel32 = 1'b0;
        n_tests++;
        if (busy32 !== 1'b0 || res32 !== last_res) begin
          n_fail++;
          $display("FAIL cancel_abort: busy=%b res=%h, want busy=0 res=%h",
                   busy32, res32, last_res);
        end
      end
      if (c == 12) begin
        e = model32(2'b01, 32'hFFFF_FF9C, 32'd7);
        sb_q.push_back(e);
        start32 = 1'b1;
        op32    = 2'b01;
        a32     = 32'hFFFF_FF9C;
        b32     = 32'd7;
      end
      if (c == 13) start32 = 1'b0;
      if (done32 === 1'b1) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = c;
          e = sb_q.pop_front();
          n_tests++;
          if (res32 !== e.res) begin
            n_fail++;
            $display("FAIL cancel_restart_result: got %h, want %h", res32, e.res);
          end
          last_res = e.res;
        end
      end
    end
    n_tests++;
    if (n_done != 1 || done_cyc != 45) begin
      n_fail++;
      $display("FAIL cancel_restart_done: %0d pulses, first at cycle %0d, want 1 at 45",
               n_done, done_cyc);
    end
    // Start together with cancel is dropped.
    @(negedge clk);
    start32  = 1'b1;
    cancel32 = 1'b1;
    op32     = 2'b00;
    a32      = 32'd9;
    b32      = 32'd0;
    @(negedge clk);
    start32  = 1'b0;
    cancel32 = 1'b0;
    n_tests++;
    if (busy32 !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_with_start_busy: busy=%b, want 0", busy32);
    end
    n_idle_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done32 !== 1'b0 || busy32 !== 1'b0) n_idle_done++;
    end
    n_tests++;
    if (n_idle_done != 0 || res32 !== last_res) begin
      n_fail++;
      $display("FAIL cancel_with_start_idle: %0d active cycles res=%h, want 0 and %h",
               n_idle_done, res32, last_res);
    end
  endtask

  task automatic test_width8();
    logic [7:0]  as[3], bs[3];
    logic [1:0]  ops[3];
    logic [15:0] exps[3];
    int          cyc;
    ops  = '{2'b00, 2'b01, 2'b01};
    as   = '{8'd200, 8'h80, 8'hF9};
    bs   = '{8'd3, 8'hFF, 8'd2};
    exps = '{{8'd2, 8'd66}, {8'h00, 8'h80}, {8'hFF, 8'hFD}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start8 = 1'b1;
      op8    = ops[i];
      a8     = as[i];
      b8     = bs[i];
      @(posedge clk);
      #1;
      start8 = 1'b0;
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (done8 !== 1'b1 && cyc < 20);
      n_tests++;
      if (done8 !== 1'b1 || cyc != 9) begin
        n_fail++;
        $display("FAIL w8_latency[%0d]: done=%b at cycle %0d, want cycle 9", i, done8, cyc);
      end
      n_tests++;
      if (res8 !== exps[i] || div0_8 !== 1'b0) begin
        n_fail++;
        $display("FAIL w8_result[%0d]: got %h div0=%b, want %h", i, res8, div0_8, exps[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    @(negedge clk);
    start8 = 1'b1;
    op8    = 2'b00;
    a8     = 8'd200;
    b8     = 8'd3;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy8, done8, div0_8, res8} !== 19'd0) begin
      n_fail++;
      $display("FAIL async_reset8: busy=%b done=%b div0=%b res=%h, want all zero",
               busy8, done8, div0_8, res8);
    end
    n_tests++;
    if (res32 !== 64'd0 || busy32 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset32: busy=%b res=%h, want zero", busy32, res32);
    end
    @(negedge clk);
    rst = 1'b0;
    // The unit must accept a fresh request after reset.
    @(negedge clk);
    start8 = 1'b1;
    op8    = 2'b00;
    a8     = 8'd7;
    b8     = 8'd2;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done8 !== 1'b1 && cyc < 20);
    n_tests++;
    if (done8 !== 1'b1 || cyc != 9 || res8 !== {8'd1, 8'd3}) begin
      n_fail++;
      $display("FAIL async_reset_recover: done=%b cycle %0d res=%h, want cycle 9 res 0103",
               done8, cyc, res8);
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    start32  = 1'b0;
    cancel32 = 1'b0;
    op32     = 2'b00;
    a32      = 32'd0;
    b32      = 32'd0;
    start8   = 1'b0;
    cancel8  = 1'b0;
    op8      = 2'b00;
    a8       = 8'd0;
    b8       = 8'd0;
    n_tests  = 0;
    n_fail   = 0;
    last_res = 64'd0;

    test_reset();
    test_divu();
    test_div();
    test_mul();
    test_div0();
    test_back_to_back();
    test_cancel();
    test_width8();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
